mmio_uart_bridge: RTL and testbench
===================================

MMIO_UART_BRIDGE -- requirements
Module: mmio_uart_bridge

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning the number of UART channels (1..4).
REQ-002 SHALL have parameter TX_DEPTH, default 8, meaning the per-channel TX FIFO depth in bytes (power of two, >=2).
REQ-003 SHALL have parameter RX_DEPTH, default 8, meaning the per-channel RX FIFO depth in bytes (power of two, >=2).
REQ-004 SHALL have ports clk input 1 system clock and rst input 1 reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have ports stall input 1 (pipeline freeze), req_valid input 1, req_we input 1, req_addr input 32, req_wdata input 8; these are the stage-Y memory request signals.
REQ-006 SHALL have ports sel output 1 (combinational hit on the request address region) and rdata output 32 (stage-Z read data).
REQ-007 SHALL have ports tx_data output NCH*8, tx_valid output NCH, tx_ready input NCH toward the UART transmitters.
REQ-008 SHALL have ports rx_data input NCH*8, rx_valid input NCH, rx_ready output NCH from the UART receivers.
REQ-009 SHALL have port irq output NCH, one level interrupt per channel.

Function
REQ-010 SHALL decode the region req_addr[31:28]==4'b1000, with channel = req_addr[5:4] and register = req_addr[3:2].
REQ-011 SHALL treat a channel index >= NCH as unmapped: reads return 0, writes are ignored.
REQ-012 SHALL use this per-channel map: +0x0 STATUS (RO), +0x4 RXDATA (RO, pops), +0x8 TXDATA (WO, pushes), +0xC CTRL (RW).
REQ-013 SHALL encode STATUS as: bit0 tx_not_full, bit1 rx_not_empty, bit2 tx_overflow (sticky), bits[15:8] rx_count, remaining bits 0.
REQ-014 SHALL use CTRL bit0 rx_irq_en and bit1 tx_empty_irq_en; a CTRL write with wdata bit7=1 clears tx_overflow.
REQ-015 SHALL treat a request as accepted only when req_valid & sel & !stall.
REQ-016 SHALL register read data one cycle after acceptance (latency 1); rdata holds its value while stall=1.
REQ-017 SHALL, on an accepted RXDATA read, return {24'd0, head byte} and pop the head in the same edge; a read on an empty FIFO returns 0 and leaves the FIFO unchanged.
REQ-018 SHALL, on an accepted TXDATA write, push req_wdata; a write on a full FIFO is dropped and sets tx_overflow.
REQ-019 SHALL drive tx_valid = TX FIFO not empty and tx_data = the head byte; the head pops on tx_valid & tx_ready.
REQ-020 SHALL drive rx_ready = RX FIFO not full, pushing rx_data on rx_valid & rx_ready; the receive side never drops data.
REQ-021 SHALL allow a CPU push and a UART drain on the same edge of one TX FIFO; the count is unchanged and the FIFO functions correctly even when full.
REQ-022 SHALL allow a CPU pop and a UART push on the same edge of one RX FIFO, likewise including the full and empty cases.
REQ-023 SHALL wrap pointers modulo depth and keep a count of width clog2(depth)+1.
REQ-024 SHALL drive irq[c] = (rx_irq_en & rx_not_empty) | (tx_empty_irq_en & tx_empty), combinationally from registered state.
REQ-025 SHALL make stall block only CPU-side push and pop; UART-side handshakes continue during stall.

Reset
REQ-026 SHALL, while rst=0, asynchronously clear all pointers, counts, CTRL and tx_overflow, and set rdata=0; FIFO storage is not reset.
REQ-027 SHALL hold outputs at reset values while rst=0: tx_valid=0, rx_ready=0 (held low only during reset), irq=0.
REQ-028 SHALL discard all queued bytes when reset is asserted mid-transfer; the first tx_valid after release occurs only after a new push.

Structure
REQ-029 SHALL place the region nibble, register offsets, STATUS/CTRL bit positions and the channel-field position in the shared package mmio_pkg.
REQ-030 SHALL implement each FIFO as one sub-module byte_fifo (parameter DEPTH; push, pop, full, empty, count, head), instantiated 2*NCH times.

Verification
REQ-031 SHALL verify TX ordering: write 0x41, 0x42 to 0x80000008 with tx_ready=1 -> tx_data shows 0x41 then 0x42 on consecutive handshakes.
REQ-032 SHALL verify TX overflow: TX_DEPTH+1 writes to ch0 with tx_ready=0 -> STATUS = 0x00000004 with bit0=0; a CTRL write of 0x80 clears bit2.
REQ-033 SHALL verify RX read latency: push 0x5A on rx ch1, then read 0x80000014 -> rdata=0x0000005A on the next cycle and STATUS rx_count becomes 0.
REQ-034 SHALL verify RX full/empty behaviour: with RX full, rx_ready=0; with RX full, a pop and an rx push on the same edge -> count stays RX_DEPTH; a read on empty returns 0.
REQ-035 SHALL verify stall: an RXDATA read with stall=1 for 3 cycles -> no pop, rdata holds; with stall=0 the pop occurs.
REQ-036 SHALL verify reset mid-transfer: assert rst=0 with 3 bytes queued -> tx_valid=0 and irq=0 immediately (asynchronously); after release STATUS = 0x00000001.

Source files
------------

// File: rtl/mmio_pkg.sv
// Address map, register offsets and STATUS/CTRL bit positions for the UART bridge.
// Shared by the bridge top and its tests; holds no logic beyond a STATUS packer.
package mmio_pkg;

  localparam logic [3:0] REGION     = 4'h8;
  localparam int         REGION_LSB = 28;
  localparam int         CH_LSB     = 4;
  localparam int         REG_LSB    = 2;

  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_RXDATA = 2'd1,
    REG_TXDATA = 2'd2,
    REG_CTRL   = 2'd3
  } reg_e;

  localparam int ST_TX_NOT_FULL  = 0;
  localparam int ST_RX_NOT_EMPTY = 1;
  localparam int ST_TX_OVF       = 2;
  localparam int ST_RXCNT_LSB    = 8;

  localparam int CTRL_RX_IRQ_EN       = 0;
  localparam int CTRL_TX_EMPTY_IRQ_EN = 1;
  localparam int CTRL_OVF_CLR         = 7;

  function automatic logic [31:0] pack_status(input logic       tx_not_full,
                                              input logic       rx_not_empty,
                                              input logic       tx_ovf,
                                              input logic [7:0] rx_count);
    logic [31:0] s;
    s                        = '0;
    s[ST_TX_NOT_FULL]        = tx_not_full;
    s[ST_RX_NOT_EMPTY]       = rx_not_empty;
    s[ST_TX_OVF]             = tx_ovf;
    s[ST_RXCNT_LSB +: 8]     = rx_count;
    return s;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with registered pointers/count and a combinational head; zero-latency read.
// Push while full is accepted only when a pop happens on the same edge; pop while empty is ignored.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             head
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem [DEPTH];
  logic          do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mmio_uart_bridge.sv
// MMIO slave exposing NCH UART channels (STATUS/RXDATA/TXDATA/CTRL); read data 1 cycle after accept.
// stall freezes only CPU-side accesses; UART-side valid/ready handshakes keep running.
module mmio_uart_bridge
  import mmio_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [7:0]       req_wdata,
  output logic             sel,
  output logic [31:0]      rdata,
  output logic [NCH*8-1:0] tx_data,
  output logic [NCH-1:0]   tx_valid,
  input  logic [NCH-1:0]   tx_ready,
  input  logic [NCH*8-1:0] rx_data,
  input  logic [NCH-1:0]   rx_valid,
  output logic [NCH-1:0]   rx_ready,
  output logic [NCH-1:0]   irq
);

  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;

  logic [1:0]  ch;
  reg_e        rsel;
  logic        acc;
  logic [31:0] rd_val;
  logic [31:0] rdata_q, rdata_d;
  logic        unused_addr;

  // Padded to four entries so the 2-bit channel field indexes without range issues.
  logic [31:0] status_w   [4];
  logic [7:0]  rx_head_w  [4];
  logic        rx_empty_w [4];
  logic [1:0]  ctrl_w     [4];
  logic        mapped_w   [4];

  assign ch          = req_addr[CH_LSB +: 2];
  assign rsel        = reg_e'(req_addr[REG_LSB +: 2]);
  assign sel         = (req_addr[REGION_LSB +: 4] == REGION);
  assign acc         = req_valid & sel & ~stall;
  assign unused_addr = ^{req_addr[27:6], req_addr[1:0]};

  for (genvar c = 0; c < 4; c++) begin : g_ch
    if (c < NCH) begin : g_on
      logic           hit;
      logic           tx_push, tx_pop, tx_full, tx_empty;
      logic           rx_push, rx_pop, rx_full, rx_empty;
      logic [TCW-1:0] tx_cnt;
      logic [RCW-1:0] rx_cnt;
      logic [7:0]     tx_head, rx_head;
      logic [1:0]     ctrl_q, ctrl_d;
      logic           ovf_q, ovf_d;
      logic           unused_tx_cnt;

      assign hit     = acc & (ch == 2'(c));
      assign tx_push = hit & req_we & (rsel == REG_TXDATA);
      assign tx_pop  = tx_valid[c] & tx_ready[c];
      assign rx_pop  = hit & ~req_we & (rsel == REG_RXDATA);
      assign rx_push = rx_valid[c] & rx_ready[c];

      byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (req_wdata),
        .pop   (tx_pop),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_cnt),
        .head  (tx_head)
      );

      byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (rx_data[c*8 +: 8]),
        .pop   (rx_pop),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_cnt),
        .head  (rx_head)
      );

      assign unused_tx_cnt     = ^tx_cnt;
      assign tx_valid[c]       = ~tx_empty;
      assign tx_data[c*8 +: 8] = tx_head;
      // A same-edge CPU pop frees a slot, so a full RX FIFO can still take a byte.
      assign rx_ready[c]       = rst & (~rx_full | rx_pop);
      assign irq[c]            = (ctrl_q[CTRL_RX_IRQ_EN] & ~rx_empty) |
                                 (ctrl_q[CTRL_TX_EMPTY_IRQ_EN] & tx_empty);

      always_comb begin
        ctrl_d = ctrl_q;
        ovf_d  = ovf_q;
        if (hit & req_we & (rsel == REG_CTRL)) begin
          ctrl_d = req_wdata[1:0];
          if (req_wdata[CTRL_OVF_CLR]) ovf_d = 1'b0;
        end
        if (tx_push & tx_full & ~tx_pop) ovf_d = 1'b1;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ctrl_q <= '0;
          ovf_q  <= 1'b0;
        end else begin
          ctrl_q <= ctrl_d;
          ovf_q  <= ovf_d;
        end
      end

      assign status_w[c]   = pack_status(~tx_full, ~rx_empty, ovf_q, 8'(rx_cnt));
      assign rx_head_w[c]  = rx_head;
      assign rx_empty_w[c] = rx_empty;
      assign ctrl_w[c]     = ctrl_q;
      assign mapped_w[c]   = 1'b1;
    end else begin : g_off
      assign status_w[c]   = '0;
      assign rx_head_w[c]  = '0;
      assign rx_empty_w[c] = 1'b1;
      assign ctrl_w[c]     = '0;
      assign mapped_w[c]   = 1'b0;
    end
  end

  always_comb begin
    rd_val = '0;
    if (mapped_w[ch]) begin
      case (rsel)
        REG_STATUS: rd_val = status_w[ch];
        REG_RXDATA: if (!rx_empty_w[ch]) rd_val = {24'd0, rx_head_w[ch]};
        REG_CTRL:   rd_val = {30'd0, ctrl_w[ch]};
        default:    rd_val = '0;
      endcase
    end
    rdata_d = (acc & ~req_we) ? rd_val : rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_q <= '0;
    else      rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Directed bench for mmio_uart_bridge with hand-computed expectations.
module tb_mmio_uart_bridge;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [7:0]  req_wdata;
  logic        sel;
  logic [31:0] rdata;
  logic [15:0] tx_data;
  logic [1:0]  tx_valid;
  logic [1:0]  tx_ready;
  logic [15:0] rx_data;
  logic [1:0]  rx_valid;
  logic [1:0]  rx_ready;
  logic [1:0]  irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  mmio_uart_bridge #(.NCH(2), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .sel       (sel),
    .rdata     (rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    tick();
    req_valid = 1'b0;
    d = rdata;
  endtask

  task automatic rx_push(input int c, input logic [7:0] d);
    rx_valid[c] = 1'b1; rx_data[c*8 +: 8] = d;
    tick();
    rx_valid[c] = 1'b0;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; tx_ready = '0; rx_data = '0; rx_valid = '0;
    repeat (3) tick();
    chk("rst_tx_valid", {30'd0, tx_valid}, 32'h0);
    chk("rst_rx_ready", {30'd0, rx_ready}, 32'h0);
    chk("rst_irq",      {30'd0, irq},      32'h0);
    chk("rst_rdata",    rdata,             32'h0);
    rst = 1'b1;
    tick();
    chk("post_rst_rx_ready", {30'd0, rx_ready}, 32'h3);
    cpu_read(32'h8000_0000, rd);
    chk("post_rst_status0", rd, 32'h0000_0001);

    req_addr = 32'h8000_0000; #1;
    chk("sel_hit", {31'd0, sel}, 32'h1);
    req_addr = 32'h4000_0000; #1;
    chk("sel_miss", {31'd0, sel}, 32'h0);
    tick();

    // TX ordering with the transmitter always ready
    tx_ready = 2'b01;
    cpu_write(32'h8000_0008, 8'h41);
    chk("tx_ord_vld1", {30'd0, tx_valid}, 32'h1);
    chk("tx_ord_dat1", {24'd0, tx_data[7:0]}, 32'h41);
    cpu_write(32'h8000_0008, 8'h42);
    chk("tx_ord_vld2", {30'd0, tx_valid}, 32'h1);
    chk("tx_ord_dat2", {24'd0, tx_data[7:0]}, 32'h42);
    tick();
    chk("tx_ord_done", {30'd0, tx_valid}, 32'h0);

    // TX overflow: nine writes into eight slots
    tx_ready = 2'b00;
    for (int i = 0; i < 9; i++) cpu_write(32'h8000_0008, 8'(8'h10 + i));
    cpu_read(32'h8000_0000, rd);
    chk("tx_ovf_status", rd, 32'h0000_0004);
    cpu_write(32'h8000_000C, 8'h80);
    cpu_read(32'h8000_0000, rd);
    chk("tx_ovf_cleared", rd, 32'h0000_0000);
    chk("tx_ovf_head", {24'd0, tx_data[7:0]}, 32'h10);
    tx_ready = 2'b01;
    repeat (7) tick();
    chk("tx_ovf_last_kept", {24'd0, tx_data[7:0]}, 32'h17);
    tick();
    chk("tx_ovf_drained", {30'd0, tx_valid}, 32'h0);

    // Full TX FIFO: push and drain on the same edge
    tx_ready = 2'b00;
    for (int i = 0; i < 8; i++) cpu_write(32'h8000_0008, 8'(8'h20 + i));
    tx_ready = 2'b01;
    cpu_write(32'h8000_0008, 8'h28);
    tx_ready = 2'b00;
    cpu_read(32'h8000_0000, rd);
    chk("tx_full_pushpop_status", rd, 32'h0000_0000);
    chk("tx_full_pushpop_head", {24'd0, tx_data[7:0]}, 32'h21);
    tx_ready = 2'b01;
    repeat (7) tick();
    chk("tx_full_pushpop_tail", {24'd0, tx_data[7:0]}, 32'h28);
    tick();
    chk("tx_full_pushpop_drained", {30'd0, tx_valid}, 32'h0);
    tx_ready = 2'b00;

    // Interrupts and CTRL readback
    cpu_write(32'h8000_000C, 8'h02);
    chk("irq_tx_empty", {30'd0, irq}, 32'h1);
    cpu_write(32'h8000_000C, 8'h00);
    cpu_write(32'h8000_001C, 8'h01);
    cpu_read(32'h8000_001C, rd);
    chk("ctrl1_readback", rd, 32'h0000_0001);
    chk("irq_rx_idle", {30'd0, irq}, 32'h0);

    // RX latency on channel 1
    rx_push(1, 8'h5A);
    chk("irq_rx_pending", {30'd0, irq}, 32'h2);
    cpu_read(32'h8000_0010, rd);
    chk("rx1_status_one", rd, 32'h0000_0103);
    cpu_read(32'h8000_0014, rd);
    chk("rx1_data", rd, 32'h0000_005A);
    cpu_read(32'h8000_0010, rd);
    chk("rx1_status_empty", rd, 32'h0000_0001);
    chk("irq_rx_cleared", {30'd0, irq}, 32'h0);

    // RX full, simultaneous pop+push, then drain to empty
    for (int i = 0; i < 8; i++) rx_push(0, 8'(8'h60 + i));
    chk("rx_full_ready", {31'd0, rx_ready[0]}, 32'h0);
    cpu_read(32'h8000_0000, rd);
    chk("rx_full_status", rd, 32'h0000_0803);
    rx_valid[0] = 1'b1; rx_data[7:0] = 8'h68;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0004;
    #1;
    chk("rx_full_ready_on_pop", {31'd0, rx_ready[0]}, 32'h1);
    tick();
    rx_valid[0] = 1'b0; req_valid = 1'b0;
    chk("rx_full_pop_data", rdata, 32'h0000_0060);
    cpu_read(32'h8000_0000, rd);
    chk("rx_full_count_kept", rd, 32'h0000_0803);
    for (int i = 0; i < 8; i++) begin
      cpu_read(32'h8000_0004, rd);
      chk("rx_drain", rd, 32'(8'h61 + i));
    end
    cpu_read(32'h8000_0004, rd);
    chk("rx_empty_read", rd, 32'h0);
    cpu_read(32'h8000_0000, rd);
    chk("rx_empty_status", rd, 32'h0000_0001);

    // Stall holds rdata and blocks the pop; UART side keeps pushing
    rx_push(0, 8'h77);
    cpu_read(32'h8000_0000, rd);
    chk("stall_pre_status", rd, 32'h0000_0103);
    stall = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0004;
    rx_valid[0] = 1'b1; rx_data[7:0] = 8'h78;
    tick();
    rx_valid[0] = 1'b0;
    chk("stall_hold1", rdata, 32'h0000_0103);
    tick();
    chk("stall_hold2", rdata, 32'h0000_0103);
    tick();
    chk("stall_hold3", rdata, 32'h0000_0103);
    stall = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("stall_release_pop", rdata, 32'h0000_0077);
    cpu_read(32'h8000_0000, rd);
    chk("stall_uart_push", rd, 32'h0000_0103);
    cpu_read(32'h8000_0004, rd);
    chk("stall_second_byte", rd, 32'h0000_0078);

    // Unmapped channel
    cpu_read(32'h8000_0000, rd);
    cpu_write(32'h8000_0028, 8'hEE);
    chk("unmapped_write_ignored", {30'd0, tx_valid}, 32'h0);
    cpu_read(32'h8000_0020, rd);
    chk("unmapped_read", rd, 32'h0);

    // Reset mid-transfer
    for (int i = 0; i < 3; i++) cpu_write(32'h8000_0008, 8'(8'hA0 + i));
    cpu_write(32'h8000_001C, 8'h01);
    rx_push(1, 8'h33);
    chk("mid_pre_tx_valid", {30'd0, tx_valid}, 32'h1);
    chk("mid_pre_irq", {30'd0, irq}, 32'h2);
    #3;
    rst = 1'b0;
    #1;
    chk("mid_async_tx_valid", {30'd0, tx_valid}, 32'h0);
    chk("mid_async_irq", {30'd0, irq}, 32'h0);
    chk("mid_async_rx_ready", {30'd0, rx_ready}, 32'h0);
    repeat (2) tick();
    rst = 1'b1;
    tx_ready = 2'b11;
    repeat (3) tick();
    chk("mid_post_no_tx", {30'd0, tx_valid}, 32'h0);
    cpu_read(32'h8000_0000, rd);
    chk("mid_post_status0", rd, 32'h0000_0001);
    cpu_read(32'h8000_0010, rd);
    chk("mid_post_status1", rd, 32'h0000_0001);
    cpu_write(32'h8000_0008, 8'h99);
    chk("mid_new_push_vld", {30'd0, tx_valid}, 32'h1);
    chk("mid_new_push_dat", {24'd0, tx_data[7:0]}, 32'h99);
    tick();
    chk("mid_new_push_drained", {30'd0, tx_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
